// File: rtl/frame_align_pkg.sv
// Shared definitions for the SOF frame tracker: alignment FSM encoding and
// parameter defaults used by the tracker and its bit-slip windows.
package frame_align_pkg;

  localparam int unsigned MXIO_DEFAULT         = 8;
  localparam int unsigned WORD_SIZE_DEFAULT    = 8;
  localparam int unsigned LOCK_COUNT_DEFAULT   = 8;
  localparam int unsigned UNLOCK_COUNT_DEFAULT = 4;
  localparam int unsigned ERR_W_DEFAULT        = 8;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/word_bitslip.sv
// Windowed shift: selects WORD_SIZE bits starting at offset_i from the
// two-word stream {cur_i, prev_i}, earliest bit in the LSB.
module word_bitslip
  import frame_align_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int unsigned OFF_W     = $clog2(WORD_SIZE)
) (
  input  logic [WORD_SIZE-1:0] cur_i,
  input  logic [WORD_SIZE-1:0] prev_i,
  input  logic [OFF_W-1:0]     offset_i,
  output logic [WORD_SIZE-1:0] win_o
);

  logic [2*WORD_SIZE-1:0] joined;
  logic [OFF_W:0]         idx;

  always_comb begin
    joined = {cur_i, prev_i};
    idx    = {1'b0, offset_i};
    win_o  = joined[idx +: WORD_SIZE];
  end

endmodule

// File: rtl/sof_frame_tracker.sv
// Start-of-frame tracker: hunts for the bit-slip offset that puts the SOF
// marker at bit 0, locks after repeated hits and realigns the data channels.
module sof_frame_tracker
  import frame_align_pkg::*;
#(
  parameter int unsigned MXIO         = MXIO_DEFAULT,
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEFAULT,
  parameter int unsigned LOCK_COUNT   = LOCK_COUNT_DEFAULT,
  parameter int unsigned UNLOCK_COUNT = UNLOCK_COUNT_DEFAULT,
  parameter int unsigned ERR_W        = ERR_W_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [MXIO*WORD_SIZE-1:0]    d_i,
  input  logic [WORD_SIZE-1:0]         sof_i,
  input  logic                         mask_i,
  input  logic                         resync_i,
  output logic [MXIO*WORD_SIZE-1:0]    sbits_o,
  output logic                         locked_o,
  output logic [$clog2(WORD_SIZE)-1:0] offset_o,
  output logic                         alignment_error_o,
  output logic [ERR_W-1:0]             err_cnt_o
);

  localparam int unsigned DW     = MXIO * WORD_SIZE;
  localparam int unsigned OFF_W  = $clog2(WORD_SIZE);
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);

  align_state_e         state_q, state_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 align_err_q, align_err_d;
  logic                 locked_q, locked_d;
  logic [DW-1:0]        sbits_q, sbits_d;
  logic [DW-1:0]        d_prev_q;
  logic [WORD_SIZE-1:0] sof_prev_q;

  logic [DW-1:0]        d_win;
  logic [WORD_SIZE-1:0] sof_win;
  logic                 frame_good;
  logic [OFF_W-1:0]     offset_inc;
  logic [GOOD_W-1:0]    good_inc;
  logic [MISS_W-1:0]    miss_inc;

  // One shared offset drives the SOF window and every channel window.
  word_bitslip #(.WORD_SIZE(WORD_SIZE), .OFF_W(OFF_W)) u_sof_slip (
    .cur_i    (sof_i),
    .prev_i   (sof_prev_q),
    .offset_i (offset_q),
    .win_o    (sof_win)
  );

  for (genvar ch = 0; ch < MXIO; ch++) begin : g_chan
    word_bitslip #(.WORD_SIZE(WORD_SIZE), .OFF_W(OFF_W)) u_slip (
      .cur_i    (d_i[ch*WORD_SIZE +: WORD_SIZE]),
      .prev_i   (d_prev_q[ch*WORD_SIZE +: WORD_SIZE]),
      .offset_i (offset_q),
      .win_o    (d_win[ch*WORD_SIZE +: WORD_SIZE])
    );
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    good_d      = good_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    align_err_d = 1'b0;

    frame_good = (sof_win == WORD_SIZE'(1));
    offset_inc = (offset_q == OFF_W'(WORD_SIZE - 1)) ? '0 : offset_q + OFF_W'(1);
    good_inc   = good_q + GOOD_W'(1);
    miss_inc   = miss_q + MISS_W'(1);

    if (resync_i) begin
      state_d  = ST_SEARCH;
      offset_d = '0;
      good_d   = '0;
      miss_d   = '0;
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (frame_good) begin
            state_d = ST_VERIFY;
            good_d  = GOOD_W'(1);
          end else begin
            offset_d = offset_inc;
          end
        end
        ST_VERIFY: begin
          if (frame_good) begin
            good_d = good_inc;
            if (good_inc == GOOD_W'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d  = ST_SEARCH;
            offset_d = offset_inc;
          end
        end
        ST_LOCKED: begin
          if (frame_good) begin
            miss_d = '0;
          end else if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
            // Lock lost: offset is kept so the search restarts where it was.
            state_d     = ST_SEARCH;
            miss_d      = '0;
            align_err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end else begin
            miss_d = miss_inc;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    sbits_d  = (mask_i || (state_q != ST_LOCKED)) ? '0 : d_win;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      offset_q    <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      err_cnt_q   <= '0;
      align_err_q <= 1'b0;
      locked_q    <= 1'b0;
      sbits_q     <= '0;
      d_prev_q    <= '0;
      sof_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      align_err_q <= align_err_d;
      locked_q    <= locked_d;
      sbits_q     <= sbits_d;
      d_prev_q    <= d_i;
      sof_prev_q  <= sof_i;
    end
  end

  assign sbits_o           = sbits_q;
  assign locked_o          = locked_q;
  assign offset_o          = offset_q;
  assign alignment_error_o = align_err_q;
  assign err_cnt_o         = err_cnt_q;

endmodule
